// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the two-requester memory arbiter:
//   state_t     - 2-bit FSM state encoding (IDLE, ISSUE, WAIT_RD, WAIT_WR)
//   REQ_I/REQ_D - requester index constants (instruction side, data side)
//   req_onehot  - converts a requester index into a 2-bit per-requester mask
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2,
        ST_WAIT_WR = 2'd3
    } state_t;

    localparam int REQ_I = 0;
    localparam int REQ_D = 1;

    function automatic logic [1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Combinational two-way round-robin selector.
// Ports:
//   req  [1:0] in  - per-requester request bits
//   last       in  - index of the requester served most recently
//   gnt        out - index of the selected requester (valid when any=1)
//   any        out - at least one request is present
// ---------------------------------------------------------------------------
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt,
    output logic       any
);

    always_comb begin
        any = |req;
        gnt = 1'b0;
        if (req == 2'b11) begin
            // Tie: the requester that was not served last takes its turn.
            gnt = ~last;
        end else begin
            // Single requester (or none): point at whichever bit is set.
            gnt = req[REQ_D];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one line-wide memory port (DataMemory handshake) between an
// instruction-side requester (index 0) and a data-side requester (index 1).
// One memory transaction is outstanding at a time; ties are broken
// round-robin, with requester 0 winning the first tie after reset.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   req_valid[1:0]        - per-requester request
//   req_addr0/1 [31:0]    - line address per requester
//   req_read/req_write    - per-requester operation (read wins if both set)
//   req_din0/1 [W-1:0]    - write line data per requester
//   req_ready[1:0]        - one-cycle accept pulse to the granted requester
//   resp_valid[1:0]       - one-cycle completion pulse per requester
//   resp_dout [W-1:0]     - read data, zero unless resp_valid is asserted
//   mem_input_valid       - one-cycle command strobe towards memory
//   mem_read/mem_write    - command type (zero when no command)
//   mem_addr/mem_din      - command fields (zero when no command)
//   mem_ready             - memory can accept / write has finished
//   mem_output_valid      - read data strobe from memory
//   mem_dout [W-1:0]      - read data from memory
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter  int LINE_SIZE = 16,
    localparam int W         = LINE_SIZE * 8
) (
    input  logic         clk,
    input  logic         reset,

    input  logic [1:0]   req_valid,
    input  logic [31:0]  req_addr0,
    input  logic [31:0]  req_addr1,
    input  logic [1:0]   req_read,
    input  logic [1:0]   req_write,
    input  logic [W-1:0] req_din0,
    input  logic [W-1:0] req_din1,
    output logic [1:0]   req_ready,
    output logic [1:0]   resp_valid,
    output logic [W-1:0] resp_dout,

    output logic         mem_input_valid,
    output logic         mem_read,
    output logic         mem_write,
    output logic [31:0]  mem_addr,
    output logic [W-1:0] mem_din,
    input  logic         mem_ready,
    input  logic         mem_output_valid,
    input  logic [W-1:0] mem_dout
);

    state_t       state_q, state_d;
    logic         last_grant_q, last_grant_d;
    logic         winner_q, winner_d;
    logic [31:0]  addr_q, addr_d;
    logic         rd_q, rd_d;
    logic [W-1:0] din_q, din_d;

    logic         arb_gnt;
    logic         arb_any;

    rr_arbiter2 u_rr (
        .req  (req_valid),
        .last (last_grant_q),
        .gnt  (arb_gnt),
        .any  (arb_any)
    );

    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        winner_d        = winner_q;
        addr_d          = addr_q;
        rd_d            = rd_q;
        din_d           = din_q;

        req_ready       = 2'b00;
        resp_valid      = 2'b00;
        resp_dout       = '0;
        mem_input_valid = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_addr        = '0;
        mem_din         = '0;

        case (state_q)
            ST_IDLE: begin
                // Requests are sampled only while memory is ready, so a
                // requester that drops req_valid before this point simply
                // withdraws without ever reaching memory.
                if (mem_ready && arb_any) begin
                    winner_d = arb_gnt;
                    addr_d   = arb_gnt ? req_addr1 : req_addr0;
                    din_d    = arb_gnt ? req_din1  : req_din0;
                    // Read takes precedence when both op bits are set;
                    // anything without the read bit is handled as a write.
                    rd_d     = req_read[arb_gnt];
                    state_d  = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                mem_input_valid = 1'b1;
                mem_read        = rd_q;
                mem_write       = ~rd_q;
                mem_addr        = addr_q;
                mem_din         = din_q;
                req_ready       = req_onehot(winner_q);
                state_d         = rd_q ? ST_WAIT_RD : ST_WAIT_WR;
            end

            ST_WAIT_RD: begin
                if (mem_output_valid) begin
                    resp_valid   = req_onehot(winner_q);
                    resp_dout    = mem_dout;
                    last_grant_d = winner_q;
                    state_d      = ST_IDLE;
                end
            end

            ST_WAIT_WR: begin
                // This state is entered the cycle after issue, so the first
                // mem_ready seen here is the write-completion indication.
                if (mem_ready) begin
                    resp_valid   = req_onehot(winner_q);
                    last_grant_d = winner_q;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            winner_q     <= 1'b0;
            addr_q       <= '0;
            rd_q         <= 1'b0;
            din_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
            addr_q       <= addr_d;
            rd_q         <= rd_d;
            din_q        <= din_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: a table of single transactions, hand
// sequences for round-robin order, reset mid-read and request withdrawal,
// then randomized traffic from both requesters against a reference model.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int LINE_SIZE = 16;
    localparam int W         = LINE_SIZE * 8;
    localparam int CW        = W + 34;
    localparam int NRAND     = 150;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req_valid, req_read, req_write;
    logic [31:0]  req_addr0, req_addr1;
    logic [W-1:0] req_din0, req_din1;
    logic [1:0]   req_ready, resp_valid;
    logic [W-1:0] resp_dout;
    logic         mem_input_valid, mem_read, mem_write;
    logic [31:0]  mem_addr;
    logic [W-1:0] mem_din;
    logic         mem_ready, mem_output_valid;
    logic [W-1:0] mem_dout;

    always #5 clk = ~clk;

    mem_arbiter #(.LINE_SIZE(LINE_SIZE)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_addr0        (req_addr0),
        .req_addr1        (req_addr1),
        .req_read         (req_read),
        .req_write        (req_write),
        .req_din0         (req_din0),
        .req_din1         (req_din1),
        .req_ready        (req_ready),
        .resp_valid       (resp_valid),
        .resp_dout        (resp_dout),
        .mem_input_valid  (mem_input_valid),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_addr         (mem_addr),
        .mem_din          (mem_din),
        .mem_ready        (mem_ready),
        .mem_output_valid (mem_output_valid),
        .mem_dout         (mem_dout)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Contents of a line never written: the address replicated across it.
    function automatic logic [W-1:0] fill(input logic [31:0] a);
        return {(W/32){a}};
    endfunction

    function automatic logic [W-1:0] ln(input logic [31:0] x);
        return {{(W-32){1'b0}}, x};
    endfunction

    // ---------------- memory device model ----------------
    logic [W-1:0] dev_mem [logic [31:0]];
    bit           mem_auto      = 1'b1;
    bit           lat_rand      = 1'b0;
    int           lat_cfg       = 2;
    logic         mem_ready_man = 1'b1;
    bit           dev_busy      = 1'b0;
    int           dev_cnt       = 0;
    logic         dev_rd;
    logic [31:0]  dev_addr;
    logic [W-1:0] dev_din;

    initial begin
        mem_ready        = 1'b1;
        mem_output_valid = 1'b0;
        mem_dout         = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_output_valid) begin
                mem_output_valid = 1'b0;
                mem_dout         = '0;
            end
            if (!mem_auto) begin
                mem_ready = mem_ready_man;
            end else if (dev_busy) begin
                dev_cnt--;
                if (dev_cnt == 0) begin
                    dev_busy  = 1'b0;
                    mem_ready = 1'b1;
                    if (dev_rd) begin
                        mem_output_valid = 1'b1;
                        mem_dout = dev_mem.exists(dev_addr) ? dev_mem[dev_addr] : fill(dev_addr);
                    end else begin
                        dev_mem[dev_addr] = dev_din;
                    end
                end
            end else if (mem_input_valid && mem_ready) begin
                dev_busy  = 1'b1;
                dev_rd    = mem_read;
                dev_addr  = mem_addr;
                dev_din   = mem_din;
                dev_cnt   = lat_rand ? int'($urandom_range(1, 6)) : lat_cfg;
                mem_ready = 1'b0;
            end
        end
    end

    // ---------------- monitor and scoreboard ----------------
    int           n_issue = 0, n_resp = 0, n_ready = 0;
    bit           mon_en  = 1'b0;
    bit [1:0]     served  = 2'b00;
    bit [1:0]     prev_wait = 2'b00;
    bit           out_busy = 1'b0;
    int           out_w, mon_w;
    bit           out_rd;
    logic [31:0]  out_addr;
    logic [W-1:0] out_din;
    logic [W-1:0] ref_mem [logic [31:0]];
    logic [31:0]  tx_addr [2];
    bit           tx_rd   [2];
    logic [W-1:0] tx_din  [2];

    initial begin
        forever begin
            @(negedge clk);
            if (!mem_input_valid) begin
                chk("mem_fields_zero", {mem_read, mem_write, mem_addr}, '0);
                chk("mem_din_zero", mem_din, '0);
            end
            if (resp_valid == 2'b00)
                chk("resp_dout_zero", resp_dout, '0);
            chk("ready_iff_issue", req_ready != 2'b00, mem_input_valid);
            if (req_ready != 2'b00) n_ready++;
            if (mem_input_valid) begin
                n_issue++;
                chk("ready_onehot", $countones(req_ready), 1);
                mon_w = req_ready[1] ? 1 : 0;
                served[mon_w] = 1'b1;
                if (mon_en) begin
                    chk("one_outstanding", out_busy, 0);
                    chk("rr_fair", prev_wait[1-mon_w], 0);
                    prev_wait = 2'b00;
                    prev_wait[1-mon_w] = req_valid[1-mon_w];
                    chk("iss_addr", mem_addr, tx_addr[mon_w]);
                    chk("iss_rd", mem_read, tx_rd[mon_w]);
                    chk("iss_wr", mem_write, !tx_rd[mon_w]);
                    if (!tx_rd[mon_w]) chk("iss_din", mem_din, tx_din[mon_w]);
                    out_busy = 1'b1;
                    out_w    = mon_w;
                    out_rd   = tx_rd[mon_w];
                    out_addr = tx_addr[mon_w];
                    out_din  = tx_din[mon_w];
                end
            end
            if (resp_valid != 2'b00) begin
                n_resp++;
                if (mon_en) begin
                    chk("resp_outstanding", out_busy, 1);
                    chk("resp_who", resp_valid, 2'b01 << out_w);
                    if (out_rd)
                        chk("resp_data", resp_dout,
                            ref_mem.exists(out_addr) ? ref_mem[out_addr] : fill(out_addr));
                    else
                        ref_mem[out_addr] = out_din;
                    out_busy = 1'b0;
                end
                $display("txn resp_valid=%b dout=%h", resp_valid, resp_dout);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic reset_dut();
        @(posedge clk);
        #2;
        reset     = 1'b1;
        req_valid = 2'b00;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic wait_issue(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (mem_input_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout: no mem_input_valid in %0d cycles, required one", budget);
        end
    endtask

    task automatic wait_resp(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (resp_valid != 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL resp_timeout: no resp_valid in %0d cycles, required one", budget);
        end
    endtask

    typedef struct {
        logic [1:0]   valid;
        logic [1:0]   rd;
        logic [1:0]   wr;
        logic [31:0]  a0;
        logic [31:0]  a1;
        logic [W-1:0] d0;
        logic [W-1:0] d1;
        int           lat;
        int           exp_w;
        bit           exp_rd;
        logic [31:0]  exp_addr;
        logic [W-1:0] exp_din;
        logic [W-1:0] exp_dout;
    } vec_t;

    vec_t vecs [8];

    task automatic run_vec(input vec_t v, input int idx);
        bit ok;
        int iss0;
        lat_cfg = v.lat;
        iss0    = n_issue;
        @(posedge clk);
        #2;
        req_valid = v.valid;
        req_read  = v.rd;
        req_write = v.wr;
        req_addr0 = v.a0;
        req_addr1 = v.a1;
        req_din0  = v.d0;
        req_din1  = v.d1;
        wait_issue(10, ok);
        if (ok) begin
            chk($sformatf("vec%0d_ready", idx), req_ready, 2'b01 << v.exp_w);
            chk($sformatf("vec%0d_rd", idx), mem_read, v.exp_rd);
            chk($sformatf("vec%0d_wr", idx), mem_write, !v.exp_rd);
            chk($sformatf("vec%0d_addr", idx), mem_addr, v.exp_addr);
            if (!v.exp_rd) chk($sformatf("vec%0d_din", idx), mem_din, v.exp_din);
            @(posedge clk);
            #2;
            req_valid = 2'b00;
            chk($sformatf("vec%0d_issue_pulse", idx), {mem_input_valid, req_ready}, 0);
            wait_resp(v.lat + 10, ok);
            if (ok) begin
                chk($sformatf("vec%0d_resp", idx), resp_valid, 2'b01 << v.exp_w);
                if (v.exp_rd) chk($sformatf("vec%0d_dout", idx), resp_dout, v.exp_dout);
            end
            @(negedge clk);
            chk($sformatf("vec%0d_resp_pulse", idx), resp_valid, 0);
            chk($sformatf("vec%0d_issue_count", idx), n_issue - iss0, 1);
        end else begin
            req_valid = 2'b00;
        end
    endtask

    // ---------------- main sequence ----------------
    bit           ok;
    int           n0, r0, gen, op;
    bit [1:0]     pend;
    logic [31:0]  ra;
    logic [W-1:0] rdat;

    initial begin
        reset     = 1'b1;
        req_valid = 2'b00;
        req_read  = 2'b00;
        req_write = 2'b00;
        req_addr0 = '0;
        req_addr1 = '0;
        req_din0  = '0;
        req_din1  = '0;
        dev_mem[32'h10] = {(W/8){8'hAA}};

        vecs[0] = '{2'b01, 2'b01, 2'b00, 32'h10, 32'h0, '0, '0, 50, 0, 1'b1, 32'h10, '0, {(W/8){8'hAA}}};
        vecs[1] = '{2'b10, 2'b00, 2'b10, 32'h0, 32'h3, '0, ln(32'h1234), 3, 1, 1'b0, 32'h3, ln(32'h1234), '0};
        vecs[2] = '{2'b11, 2'b11, 2'b00, 32'h3, 32'h20, '0, '0, 2, 0, 1'b1, 32'h3, '0, ln(32'h1234)};
        vecs[3] = '{2'b11, 2'b10, 2'b01, 32'h20, 32'h3, ln(32'h55), '0, 4, 1, 1'b1, 32'h3, '0, ln(32'h1234)};
        vecs[4] = '{2'b11, 2'b01, 2'b11, 32'h20, 32'h21, ln(32'h77), ln(32'h99), 1, 0, 1'b1, 32'h20, '0, {(W/32){32'h20}}};
        vecs[5] = '{2'b01, 2'b00, 2'b01, 32'h7, 32'h0, ln(32'hBEEF), '0, 2, 0, 1'b0, 32'h7, ln(32'hBEEF), '0};
        vecs[6] = '{2'b11, 2'b11, 2'b00, 32'h7, 32'h10, '0, '0, 3, 1, 1'b1, 32'h10, '0, {(W/8){8'hAA}}};
        vecs[7] = '{2'b11, 2'b01, 2'b10, 32'h7, 32'h30, '0, ln(32'h5), 2, 0, 1'b1, 32'h7, '0, ln(32'hBEEF)};

        // Reset state
        reset_dut();
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_dout", resp_dout, 0);
        chk("rst_mem_cmd", {mem_input_valid, mem_read, mem_write}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_din", mem_din, 0);

        // Table of single transactions (round-robin state carries across rows)
        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Round-robin order after reset: 0, then 1, then 0 again
        reset_dut();
        lat_cfg = 2;
        @(posedge clk);
        #2;
        req_valid = 2'b11;
        req_read  = 2'b11;
        req_write = 2'b00;
        req_addr0 = 32'h40;
        req_addr1 = 32'h41;
        wait_issue(10, ok);
        if (ok) chk("rr_first", req_ready, 2'b01);
        @(posedge clk);
        #2;
        req_valid = 2'b10;
        wait_resp(20, ok);
        wait_issue(10, ok);
        if (ok) chk("rr_second", req_ready, 2'b10);
        @(posedge clk);
        #2;
        req_valid = 2'b11;
        req_addr1 = 32'h42;
        wait_resp(20, ok);
        wait_issue(10, ok);
        if (ok) chk("rr_third", req_ready, 2'b01);
        @(posedge clk);
        #2;
        req_valid = 2'b00;
        wait_resp(20, ok);

        // Reset while waiting for read data; the late data must be ignored
        lat_cfg = 20;
        n0 = n_resp;
        @(posedge clk);
        #2;
        req_valid = 2'b01;
        req_read  = 2'b01;
        req_addr0 = 32'h50;
        wait_issue(10, ok);
        @(posedge clk);
        #2;
        req_valid = 2'b00;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("rst_wait_no_resp", n_resp - n0, 0);
        chk("rst_wait_idle_outputs", {mem_input_valid, req_ready, resp_valid}, 0);
        lat_cfg = 2;
        @(posedge clk);
        #2;
        req_valid = 2'b11;
        req_read  = 2'b11;
        wait_issue(4, ok);
        if (ok) chk("rst_wait_first_tie", req_ready, 2'b01);
        @(posedge clk);
        #2;
        req_valid = 2'b00;
        wait_resp(20, ok);

        // Request withdrawn while memory is busy: never issued
        repeat (2) @(posedge clk);
        mem_auto      = 1'b0;
        mem_ready_man = 1'b0;
        n0 = n_issue;
        r0 = n_ready;
        @(posedge clk);
        #2;
        req_valid = 2'b01;
        req_read  = 2'b01;
        req_addr0 = 32'h60;
        repeat (5) @(posedge clk);
        #2;
        req_valid     = 2'b00;
        mem_ready_man = 1'b1;
        repeat (10) @(negedge clk);
        chk("withdraw_no_issue", n_issue - n0, 0);
        chk("withdraw_no_ready", n_ready - r0, 0);
        mem_auto = 1'b1;

        // Randomized traffic from both requesters
        @(posedge clk);
        mon_en    = 1'b1;
        prev_wait = 2'b00;
        out_busy  = 1'b0;
        lat_rand  = 1'b1;
        served    = 2'b00;
        pend      = 2'b00;
        gen       = 0;
        n0        = n_resp;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(posedge clk);
            #2;
            for (int i = 0; i < 2; i++) begin
                if (served[i]) begin
                    served[i]    = 1'b0;
                    pend[i]      = 1'b0;
                    req_valid[i] = 1'b0;
                end
                if (!pend[i] && gen < NRAND && $urandom_range(0, 3) != 0) begin
                    ra = 32'h100 + $urandom_range(0, 7);
                    op = $urandom_range(0, 2);
                    for (int k = 0; k < W/32; k++) rdat[32*k +: 32] = $urandom;
                    tx_addr[i] = ra;
                    tx_rd[i]   = (op != 1);
                    tx_din[i]  = rdat;
                    if (i == 0) begin
                        req_addr0 = ra;
                        req_din0  = rdat;
                    end else begin
                        req_addr1 = ra;
                        req_din1  = rdat;
                    end
                    req_read[i]  = (op != 1);
                    req_write[i] = (op != 0);
                    req_valid[i] = 1'b1;
                    pend[i]      = 1'b1;
                    gen++;
                end
            end
            if (gen == NRAND && pend == 2'b00 && !out_busy) break;
        end
        chk("rand_all_completed", n_resp - n0, NRAND);
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter LINE_SIZE, default 16, meaning line width in bytes; W = LINE_SIZE*8.
REQ-002 The block SHALL have port clk  input  1  clock.
REQ-003 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port req_valid  input  2  per-requester request (bit 0 = I-side, bit 1 = D-side).
REQ-005 The block SHALL have ports req_addr0 and req_addr1  input  32  line address, already shifted by log2(LINE_SIZE).
REQ-006 The block SHALL have ports req_read and req_write  input  2  per-requester operation.
REQ-007 The block SHALL have ports req_din0 and req_din1  input  W  write line data.
REQ-008 The block SHALL have port req_ready  output  2  one-cycle accept pulse to the granted requester.
REQ-009 The block SHALL have port resp_valid  output  2  one-cycle completion pulse per requester.
REQ-010 The block SHALL have port resp_dout  output  W  read line data, valid only with resp_valid.
REQ-011 The block SHALL have memory-side ports mem_input_valid, mem_read, mem_write (output, 1 each), mem_addr (output, 32), mem_din (output, W), mem_ready, mem_output_valid (input, 1 each) and mem_dout (input, W), matching the existing DataMemory handshake.

Function
REQ-012 The FSM SHALL have states IDLE, ISSUE, WAIT_RD, WAIT_WR.
REQ-013 In IDLE with mem_ready=1 and any req_valid=1, the block SHALL grant one requester and latch its addr/op/din, then move to ISSUE.
REQ-014 With both requesters valid, the block SHALL grant the one not granted last (round-robin); after reset last_grant SHALL be 1, so requester 0 wins the first tie.
REQ-015 In ISSUE the block SHALL drive mem_input_valid=1 for exactly one cycle with the latched fields and pulse req_ready[winner]; the request is in IDLE at cycle t, so issue occurs at t+1.
REQ-016 From ISSUE the FSM SHALL go to WAIT_RD for a read and WAIT_WR for a write.
REQ-017 In WAIT_RD on mem_output_valid=1, the block SHALL pulse resp_valid[winner], drive resp_dout=mem_dout in the same cycle, and return to IDLE.
REQ-018 In WAIT_WR, when mem_ready first returns to 1 at least one cycle after issue, the block SHALL pulse resp_valid[winner] and return to IDLE.
REQ-019 last_grant SHALL update on the completion pulse only.
REQ-020 A requester SHALL hold req_valid and its fields until req_ready; deassertion before the grant SHALL withdraw the request without issue.
REQ-021 If req_read and req_write are both set, the block SHALL treat the request as a read.
REQ-022 Memory outputs SHALL be 0 whenever mem_input_valid=0; resp_dout SHALL be 0 when no resp_valid is asserted.
REQ-023 Only one memory transaction SHALL be outstanding at a time; new requests SHALL wait in IDLE.
REQ-024 Starvation SHALL be bounded: a continuously valid requester is granted within 2 transactions.

Reset
REQ-025 On reset, the FSM SHALL go to IDLE, last_grant SHALL be set to 1, latched fields SHALL clear to 0, and all outputs SHALL be 0 from the next cycle.
REQ-026 Reset during ISSUE or WAIT SHALL abandon the transaction with no resp_valid pulse; a late mem_output_valid arriving in IDLE SHALL be ignored.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (2-bit) and the requester index constants REQ_I=0 and REQ_D=1.
REQ-028 Round-robin selection SHALL be a combinational sub-module rr_arbiter2 (inputs req[1:0] and last; output gnt index and any).

Verification
REQ-029 Scenario: a single I-side read at addr 0x10; memory returns 0xAA..AA after 50 cycles -> mem_input_valid pulses once with mem_addr=0x10, then resp_valid=2'b01 for one cycle with resp_dout=0xAA..AA.
REQ-030 Scenario: both requesters valid after reset -> requester 0 is granted first and requester 1 second; if both are re-requested, requester 0 is granted third.
REQ-031 Scenario: a D-side write of 0x1234 to addr 0x3 -> mem_write=1, mem_din=0x1234 for one cycle, and resp_valid=2'b10 after mem_ready returns to 1.
REQ-032 Scenario: reset asserted while in WAIT_RD -> no resp_valid pulse, FSM in IDLE, and a later mem_output_valid is ignored.
REQ-033 Scenario: req_valid[0] drops while mem_ready=0 -> no issue occurs and no req_ready pulse is produced.
